exec_muldiv_stage: RTL and testbench

- Parametrised next-generation execute stage: single-cycle integer ALU plus an iterative RV32M multiply/divide unit.
- Uses valid/ready handshakes on both sides instead of a global stall bit.
- Sits between decode and memory stages; while a multi-cycle op is in flight it back-pressures decode and holds its registered result until memory accepts it.

---
 rtl/exec_muldiv_stage_if.sv | 33 +++
 rtl/exec_muldiv_stage.sv | 200 ++++++++++++++++++++
 tb/tb_exec_muldiv_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_muldiv_stage_if.sv
// Decode-to-execute and execute-to-memory handshake bundle for exec_muldiv_stage.
// The stage connects through the slave modport; decode/memory drive the master side.
interface exec_muldiv_stage_if #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int PC_WIDTH = 32
);
  logic                e_i_valid;
  logic                e_o_ready;
  logic [4:0]          e_i_op;
  logic [DWIDTH-1:0]   e_i_a;
  logic [DWIDTH-1:0]   e_i_b;
  logic [AWIDTH-1:0]   e_i_addr_rd;
  logic [PC_WIDTH-1:0] e_i_pc;
  logic                e_i_flush;
  logic                e_o_valid;
  logic                e_i_ready;
  logic [DWIDTH-1:0]   e_o_result;
  logic [AWIDTH-1:0]   e_o_addr_rd;
  logic [PC_WIDTH-1:0] e_o_pc;
  logic                e_o_we;
  logic                e_o_busy;

  modport slave (
    input  e_i_valid, e_i_op, e_i_a, e_i_b, e_i_addr_rd, e_i_pc, e_i_flush, e_i_ready,
    output e_o_ready, e_o_valid, e_o_result, e_o_addr_rd, e_o_pc, e_o_we, e_o_busy
  );

  modport master (
    output e_i_valid, e_i_op, e_i_a, e_i_b, e_i_addr_rd, e_i_pc, e_i_flush, e_i_ready,
    input  e_o_ready, e_o_valid, e_o_result, e_o_addr_rd, e_o_pc, e_o_we, e_o_busy
  );
endinterface

// File: rtl/exec_muldiv_stage.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier and restoring divider,
// valid/ready on both sides, result held until the memory stage takes it.
module exec_muldiv_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic                e_clk,
  input logic                e_rst,
  exec_muldiv_stage_if.slave bus
);

  localparam int SHW = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0]    MIN_S    = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DWIDTH-1);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1,  OP_SLT    = 5'd2,  OP_SLTU  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_OR   = 5'd5,  OP_AND    = 5'd6,  OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA  = 5'd9,  OP_MUL    = 5'd16, OP_MULH  = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18, OP_MULHU = 5'd19, OP_DIV = 5'd20, OP_DIVU = 5'd21;
  localparam logic [4:0] OP_REM = 5'd22, OP_REMU = 5'd23;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                state_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [4:0]            op_reg;
  logic                  sign_reg;
  logic [DWIDTH-1:0]     opnd_reg;
  logic [2*DWIDTH-1:0]   acc_reg;
  logic [AWIDTH-1:0]     pend_rd_reg;
  logic [PC_WIDTH-1:0]   pend_pc_reg;
  logic                  valid_reg;
  logic [DWIDTH-1:0]     result_reg;
  logic [AWIDTH-1:0]     addr_reg;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic                  we_reg;
  logic                  busy_reg;

  logic              accept, xfer;
  logic              is_mul, is_div, div_special, fast;
  logic              a_signed, b_signed, a_neg, b_neg, sign_next;
  logic [DWIDTH-1:0] a_abs, b_abs, alu_res, done_res;
  logic [SHW-1:0]    shamt;

  assign bus.e_o_ready   = e_rst && (state_reg == IDLE) && (!valid_reg || bus.e_i_ready);
  assign bus.e_o_valid   = valid_reg;
  assign bus.e_o_result  = result_reg;
  assign bus.e_o_addr_rd = addr_reg;
  assign bus.e_o_pc      = pc_reg;
  assign bus.e_o_we      = we_reg;
  assign bus.e_o_busy    = busy_reg;

  assign accept = bus.e_i_valid && bus.e_o_ready;
  assign xfer   = valid_reg && bus.e_i_ready;
  assign shamt  = bus.e_i_b[SHW-1:0];

  assign is_mul = bus.e_i_op[4] && (bus.e_i_op[3:2] == 2'b00);
  assign is_div = bus.e_i_op[4] && (bus.e_i_op[3:2] == 2'b01);

  // Divide by zero and signed overflow resolve in one cycle without touching the iterator.
  assign div_special = is_div && ((bus.e_i_b == '0) ||
                       (((bus.e_i_op == OP_DIV) || (bus.e_i_op == OP_REM)) &&
                        (bus.e_i_a == MIN_S) && (bus.e_i_b == '1)));
  assign fast = !is_mul && !(is_div && !div_special);

  assign a_signed  = (bus.e_i_op == OP_MUL) || (bus.e_i_op == OP_MULH) ||
                     (bus.e_i_op == OP_MULHSU) || (bus.e_i_op == OP_DIV) || (bus.e_i_op == OP_REM);
  assign b_signed  = (bus.e_i_op == OP_MUL) || (bus.e_i_op == OP_MULH) ||
                     (bus.e_i_op == OP_DIV) || (bus.e_i_op == OP_REM);
  assign a_neg     = a_signed && bus.e_i_a[DWIDTH-1];
  assign b_neg     = b_signed && bus.e_i_b[DWIDTH-1];
  assign a_abs     = a_neg ? -bus.e_i_a : bus.e_i_a;
  assign b_abs     = b_neg ? -bus.e_i_b : bus.e_i_b;
  // A remainder takes the dividend's sign only.
  assign sign_next = (bus.e_i_op == OP_REM) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    alu_res = '0;
    case (bus.e_i_op)
      OP_ADD:  alu_res = bus.e_i_a + bus.e_i_b;
      OP_SUB:  alu_res = bus.e_i_a - bus.e_i_b;
      OP_SLT:  alu_res = {{(DWIDTH-1){1'b0}}, ($signed(bus.e_i_a) < $signed(bus.e_i_b))};
      OP_SLTU: alu_res = {{(DWIDTH-1){1'b0}}, (bus.e_i_a < bus.e_i_b)};
      OP_XOR:  alu_res = bus.e_i_a ^ bus.e_i_b;
      OP_OR:   alu_res = bus.e_i_a | bus.e_i_b;
      OP_AND:  alu_res = bus.e_i_a & bus.e_i_b;
      OP_SLL:  alu_res = bus.e_i_a << shamt;
      OP_SRL:  alu_res = bus.e_i_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.e_i_a) >>> shamt);
      OP_DIV:  alu_res = (bus.e_i_b == '0) ? '1 : MIN_S;
      OP_DIVU: alu_res = '1;
      OP_REM:  alu_res = (bus.e_i_b == '0) ? bus.e_i_a : '0;
      OP_REMU: alu_res = bus.e_i_a;
      default: alu_res = '0;
    endcase
  end

  // Multiply: low half of acc holds the multiplier, high half accumulates, shift right each step.
  logic [DWIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_reg[2*DWIDTH-1:DWIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);

  // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per trial subtraction.
  logic              div_ge;
  logic [DWIDTH-1:0] div_diff;
  assign div_ge   = acc_reg[2*DWIDTH-1:DWIDTH-1] >= {1'b0, opnd_reg};
  assign div_diff = acc_reg[2*DWIDTH-2:DWIDTH-1] - opnd_reg;

  logic [2*DWIDTH-1:0] prod_fix;
  logic [DWIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = sign_reg ? -acc_reg : acc_reg;
  assign quo_fix  = sign_reg ? -acc_reg[DWIDTH-1:0] : acc_reg[DWIDTH-1:0];
  assign rem_fix  = sign_reg ? -acc_reg[2*DWIDTH-1:DWIDTH] : acc_reg[2*DWIDTH-1:DWIDTH];

  always_comb begin
    done_res = rem_fix;
    case (op_reg)
      OP_MUL:                         done_res = prod_fix[DWIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   done_res = prod_fix[2*DWIDTH-1:DWIDTH];
      OP_DIV, OP_DIVU:                done_res = quo_fix;
      default:                        done_res = rem_fix;
    endcase
  end

  always_ff @(posedge e_clk or negedge e_rst) begin
    if (!e_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      sign_reg    <= 1'b0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      pend_rd_reg <= '0;
      pend_pc_reg <= '0;
      valid_reg   <= 1'b0;
      result_reg  <= '0;
      addr_reg    <= '0;
      pc_reg      <= '0;
      we_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (bus.e_i_flush) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      if (xfer) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (accept && fast) begin
            valid_reg  <= 1'b1;
            result_reg <= alu_res;
            addr_reg   <= bus.e_i_addr_rd;
            pc_reg     <= bus.e_i_pc;
            we_reg     <= |bus.e_i_addr_rd;
          end else if (accept) begin
            state_reg   <= is_mul ? MUL : DIV;
            busy_reg    <= 1'b1;
            cnt_reg     <= '0;
            op_reg      <= bus.e_i_op;
            sign_reg    <= sign_next;
            pend_rd_reg <= bus.e_i_addr_rd;
            pend_pc_reg <= bus.e_i_pc;
            opnd_reg    <= is_mul ? a_abs : b_abs;
            acc_reg     <= {{DWIDTH{1'b0}}, (is_mul ? b_abs : a_abs)};
          end
        end
        MUL, DIV: begin
          if (state_reg == MUL) begin
            acc_reg <= {mul_sum, acc_reg[DWIDTH-1:1]};
          end else if (div_ge) begin
            acc_reg <= {div_diff, acc_reg[DWIDTH-2:0], 1'b1};
          end else begin
            acc_reg <= {acc_reg[2*DWIDTH-2:0], 1'b0};
          end
          if (cnt_reg == CNT_LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          valid_reg  <= 1'b1;
          result_reg <= done_res;
          addr_reg   <= pend_rd_reg;
          pc_reg     <= pend_pc_reg;
          we_reg     <= |pend_rd_reg;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv_stage.sv
// Randomised and directed bench for exec_muldiv_stage against an arithmetic reference model.
module tb_exec_muldiv_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 32;
  localparam logic [31:0] MIN_S = 32'h8000_0000;

  logic e_clk = 1'b0;
  logic e_rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 e_clk = ~e_clk;

  exec_muldiv_stage_if #(.DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW)) bus ();

  exec_muldiv_stage #(.DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW), .CNT_WIDTH(6)) dut (
    .e_clk (e_clk),
    .e_rst (e_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge e_clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    r  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd3:  r = (a < b) ? 32'd1 : 32'd0;
      5'd4:  r = a ^ b;
      5'd5:  r = a | b;
      5'd6:  r = a & b;
      5'd7:  r = a << sh;
      5'd8:  r = a >> sh;
      5'd9:  r = $unsigned($signed(a) >>> sh);
      5'd16: begin p = sa * sb; r = p[31:0]; end
      5'd17: begin p = sa * sb; r = p[63:32]; end
      5'd18: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      5'd19: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      5'd20: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MIN_S && b == 32'hFFFF_FFFF) r = MIN_S;
        else begin p = sa / sb; r = p[31:0]; end
      end
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) r = a;
        else if (a == MIN_S && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      5'd23: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // M-unit ops go iterative unless they are a divide by zero or signed divide overflow.
  function automatic bit is_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd19) return 1'b1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0) return 1'b0;
      if ((op == 5'd20 || op == 5'd22) && a == MIN_S && b == 32'hFFFF_FFFF) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] pc);
    bus.e_i_valid   = 1'b1;
    bus.e_i_op      = op;
    bus.e_i_a       = a;
    bus.e_i_b       = b;
    bus.e_i_addr_rd = rd;
    bus.e_i_pc      = pc;
  endtask

  // Issue one op, wait for its result, optionally stall the memory side for `hold` cycles.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    logic [31:0] exp_res, pcv;
    bit          iter, rdy_seen;
    int          guard, lat, exp_lat;
    string       nm;
    nm      = $sformatf("op%0d a=%08h b=%08h", op, a, b);
    exp_res = model(op, a, b);
    iter    = is_iter(op, a, b);
    // accept edge plus DWIDTH+1 further edges = DWIDTH+2 edges for iterative ops
    exp_lat = iter ? DW + 1 : 0;
    pcv     = $urandom;
    guard   = 0;
    while (!bus.e_o_ready && guard < 100) begin tick(); guard++; end
    check({nm, " ready_before_accept"}, bus.e_o_ready, 1);
    drive_op(op, a, b, rd, pcv);
    bus.e_i_ready = (hold == 0);
    tick();
    bus.e_i_valid = 1'b0;
    check({nm, " busy"}, bus.e_o_busy, iter);
    lat = 0;
    rdy_seen = 1'b0;
    while (!bus.e_o_valid && lat < 100) begin
      if (bus.e_o_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " result"}, bus.e_o_result, exp_res);
    check({nm, " addr_rd"}, bus.e_o_addr_rd, rd);
    check({nm, " pc"}, bus.e_o_pc, pcv);
    check({nm, " we"}, bus.e_o_we, (rd != 0));
    if (iter) check({nm, " ready_low_while_iter"}, rdy_seen, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({nm, " held_valid"}, bus.e_o_valid, 1);
      check({nm, " held_result"}, bus.e_o_result, exp_res);
      check({nm, " held_pc"}, bus.e_o_pc, pcv);
      check({nm, " ready_low_while_held"}, bus.e_o_ready, 0);
    end
    bus.e_i_ready = 1'b1;
    tick();
    check({nm, " transferred"}, bus.e_o_valid, 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN_S;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_pool [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                               5'd12, 5'd27};

  initial begin
    bit seen;
    bus.e_i_valid   = 1'b0;
    bus.e_i_op      = '0;
    bus.e_i_a       = '0;
    bus.e_i_b       = '0;
    bus.e_i_addr_rd = '0;
    bus.e_i_pc      = '0;
    bus.e_i_flush   = 1'b0;
    bus.e_i_ready   = 1'b1;

    #12;
    check("reset valid", bus.e_o_valid, 0);
    check("reset busy", bus.e_o_busy, 0);
    check("reset result", bus.e_o_result, 0);
    check("reset we", bus.e_o_we, 0);
    tick();
    e_rst = 1'b1;
    tick();
    check("ready after reset", bus.e_o_ready, 1);

    do_op(5'd0, 32'd5, 32'hFFFF_FFFF, 5'd3, 0);
    do_op(5'd0, 32'd5, 32'hFFFF_FFFF, 5'd3, 3);
    do_op(5'd21, 32'd100, 32'd7, 5'd4, 0);
    do_op(5'd23, 32'd100, 32'd7, 5'd4, 0);
    do_op(5'd20, MIN_S, 32'hFFFF_FFFF, 5'd5, 0);
    do_op(5'd22, MIN_S, 32'hFFFF_FFFF, 5'd5, 0);
    do_op(5'd20, 32'd5, 32'd0, 5'd6, 0);
    do_op(5'd22, 32'hFFFF_FFF9, 32'd0, 5'd7, 0);
    do_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    do_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1);
    do_op(5'd16, 32'h0001_0000, 32'h0001_0000, 5'd9, 0);
    do_op(5'd18, 32'hFFFF_FFFF, 32'd2, 5'd0, 0);
    do_op(5'd20, 32'hFFFF_FFF9, 32'd2, 5'd10, 2);
    do_op(5'd22, 32'hFFFF_FFF9, 32'd2, 5'd11, 0);

    // Back-to-back ALU ops: transfer and accept share an edge.
    bus.e_i_ready = 1'b1;
    drive_op(5'd0, 32'd10, 32'd20, 5'd1, 32'h100);
    tick();
    check("b2b first valid", bus.e_o_valid, 1);
    check("b2b first result", bus.e_o_result, 30);
    check("b2b ready", bus.e_o_ready, 1);
    drive_op(5'd1, 32'd10, 32'd20, 5'd2, 32'h104);
    tick();
    bus.e_i_valid = 1'b0;
    check("b2b second valid", bus.e_o_valid, 1);
    check("b2b second result", bus.e_o_result, 32'hFFFF_FFF6);
    check("b2b second pc", bus.e_o_pc, 32'h104);
    tick();
    check("b2b drained", bus.e_o_valid, 0);

    // Flush mid-divide: the divide never produces a result.
    drive_op(5'd20, 32'd1000, 32'd3, 5'd12, 32'h200);
    tick();
    bus.e_i_valid = 1'b0;
    repeat (9) tick();
    bus.e_i_flush = 1'b1;
    tick();
    bus.e_i_flush = 1'b0;
    check("flush valid", bus.e_o_valid, 0);
    check("flush busy", bus.e_o_busy, 0);
    check("flush ready", bus.e_o_ready, 1);
    seen = 1'b0;
    repeat (40) begin tick(); if (bus.e_o_valid) seen = 1'b1; end
    check("flush no late result", seen, 0);
    do_op(5'd0, 32'd7, 32'd8, 5'd13, 0);

    // Flush wins over a simultaneous accept, and drops a held result.
    drive_op(5'd0, 32'd1, 32'd1, 5'd14, 32'h300);
    bus.e_i_flush = 1'b1;
    tick();
    bus.e_i_valid = 1'b0;
    bus.e_i_flush = 1'b0;
    check("flush blocks accept", bus.e_o_valid, 0);
    bus.e_i_ready = 1'b0;
    drive_op(5'd4, 32'd3, 32'd5, 5'd14, 32'h304);
    tick();
    bus.e_i_valid = 1'b0;
    check("held before flush", bus.e_o_valid, 1);
    bus.e_i_flush = 1'b1;
    tick();
    bus.e_i_flush = 1'b0;
    bus.e_i_ready = 1'b1;
    check("flush drops held", bus.e_o_valid, 0);

    // Asynchronous reset mid-multiply.
    drive_op(5'd16, 32'd12345, 32'd678, 5'd15, 32'h400);
    tick();
    bus.e_i_valid = 1'b0;
    repeat (5) tick();
    check("busy before reset", bus.e_o_busy, 1);
    e_rst = 1'b0;
    #1;
    check("async reset valid", bus.e_o_valid, 0);
    check("async reset busy", bus.e_o_busy, 0);
    check("async reset result", bus.e_o_result, 0);
    check("async reset addr", bus.e_o_addr_rd, 0);
    check("async reset pc", bus.e_o_pc, 0);
    tick();
    tick();
    e_rst = 1'b1;
    tick();
    check("ready after re-reset", bus.e_o_ready, 1);
    seen = 1'b0;
    repeat (40) begin tick(); if (bus.e_o_valid) seen = 1'b1; end
    check("no result for reset op", seen, 0);
    do_op(5'd4, 32'h0000_00F0, 32'h0000_00FF, 5'd16, 0);

    for (int i = 0; i < 60; i++) begin
      do_op(op_pool[$urandom_range(0, 19)], rand_operand(), rand_operand(),
            5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
